// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues word reads over a
// valid/ready request channel, buffers returned words in an in-order FIFO and
// hands {instr, pc, pc+4} to decode. Redirects flush queued work and mark
// in-flight fetches to be dropped when they return.
// Optional build macro FQ_BYPASS_EN: a response that arrives while the FIFO is
// empty and decode is ready goes straight to out_* in the same cycle.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [CW-1:0] drop;
  logic [AW-1:0] tag_rd, tag_wr;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   tag_q      [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic [CW:0]   occupancy;
  logic          accept;
  logic          resp_ok;
  logic          resp_drop;
  logic          resp_keep;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [31:0]   sel_instr;
  logic [31:0]   sel_pc;

  // Credit covers both in-flight and buffered entries, so the FIFO can never
  // overflow regardless of how long decode stalls.
  assign occupancy      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < DEPTH_W);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are illegal and simply ignored.
  assign resp_ok   = imem_resp_valid && (outstanding != '0);
  assign resp_drop = resp_ok && (drop != '0);
  assign resp_keep = resp_ok && (drop == '0);

`ifdef FQ_BYPASS_EN
  assign bypass = resp_keep && (count == '0) && out_ready;
`else
  assign bypass = 1'b0;
`endif

  // A kept response landing in a redirect cycle is stale and is not stored.
  assign push = resp_keep && !bypass && !redirect_valid;
  assign pop  = (count != '0) && out_ready;

  // PC: redirect wins over sequential advance; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & ~32'h3;
    else if (accept)         pc <= pc + 32'd4;
  end

  // In-flight fetch counter: +1 per accepted request, -1 per response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding <= '0;
    else if (accept && !resp_ok) outstanding <= outstanding + CW'(1);
    else if (!accept && resp_ok) outstanding <= outstanding - CW'(1);
  end

  // Stale-response counter: on redirect every fetch still in flight after
  // this cycle must be discarded; otherwise count down as they return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              drop <= '0;
    else if (redirect_valid) drop <= outstanding - CW'(resp_ok);
    else if (resp_drop)      drop <= drop - CW'(1);
  end

  // Tag queue pointers: tags are consumed by every response, kept or dropped,
  // so they are never flushed by a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (accept)  tag_wr <= tag_wr + AW'(1);
      if (resp_ok) tag_rd <= tag_rd + AW'(1);
    end
  end

  // Tag storage: remember the address of each accepted request.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr] <= pc;
  end

  // FIFO control: redirect empties it; otherwise push/pop with a combined count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // FIFO storage: instruction word paired with its fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]    <= tag_q[tag_rd];
    end
  end

  // Output select: FIFO head, or the live response when bypassing. Fields
  // read as zero while nothing is offered.
  always_comb begin
    sel_instr = fifo_instr[rd_ptr];
    sel_pc    = fifo_pc[rd_ptr];
`ifdef FQ_BYPASS_EN
    if (bypass) begin
      sel_instr = imem_resp_data;
      sel_pc    = tag_q[tag_rd];
    end
`endif
    out_valid = (count != '0) || bypass;
    out_instr = out_valid ? sel_instr : '0;
    out_pc    = out_valid ? sel_pc : '0;
    out_pc4   = out_valid ? (sel_pc + 32'd4) : '0;
  end

  a_resp_has_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: fixed-latency memory model, address scoreboard fed
// on each accepted request and drained on each delivered instruction, plus a
// table of redirect scenarios with expected first deliveries.
module tb_fetch_queue;

`ifdef FQ_BYPASS_EN
  localparam int FIFO_LAT = 0;
`else
  localparam int FIFO_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] rpc;
    logic        second;
    logic [31:0] rpc2;
    int          lat;
    int          pre;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc4_1;
    logic [31:0] exp_pc4_2;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rdy_mode = 2;   // 0 always ready, 1 random, 2 never
  bit          rand_out = 0;
  int          n_acc = 0;
  logic [31:0] exp_req_addr;
  resp_t       resp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_pc4[$];
  int          pop_cyc[$];
  int          acc_cyc[$];
  vec_t        vecs[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    pop_pc.delete(); pop_pc4.delete(); pop_cyc.delete(); acc_cyc.delete();
  endtask

  // One clock: drive memory/ready inputs, sample outputs after settling,
  // update the model, then advance to the next falling edge.
  task automatic step();
    resp_t       r;
    resp_t       done;
    logic [31:0] e;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = resp_q[0].data;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    case (rdy_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = ($urandom_range(3) != 0);
      default: imem_req_ready = 1'b0;
    endcase
    if (rand_out) out_ready = ($urandom_range(1) == 1);
    #1;
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_addr);
      r.data = mem_word(imem_req_addr);
      r.due  = cyc + lat;
      resp_q.push_back(r);
      exp_q.push_back(exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
      n_acc++;
      acc_cyc.push_back(cyc);
    end
    if (imem_resp_valid) done = resp_q.pop_front();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pop: got pc %h expected no delivery (cycle %0d)", out_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, mem_word(e));
        check("out_pc4", out_pc4, e + 32'd4);
      end
      pop_pc.push_back(out_pc);
      pop_pc4.push_back(out_pc4);
      pop_cyc.push_back(cyc);
    end
    if (redirect_valid) begin
      check("no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
      exp_q.delete();
      exp_req_addr = redirect_pc & ~32'h3;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Stop fetching and let everything in flight be delivered.
  task automatic drain();
    rdy_mode = 2; rand_out = 0; out_ready = 1'b1; redirect_valid = 1'b0;
    repeat (15) step();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0103, 1'b0, 32'h0, 6, 3, 32'h0000_0100, 32'h0000_0108, 32'h0000_010C};
    vecs[1] = '{32'h0000_0040, 1'b1, 32'h0000_0080, 3, 2, 32'h0000_0080, 32'h0000_0088, 32'h0000_008C};
    vecs[2] = '{32'hFFFF_FFF8, 1'b0, 32'h0, 1, 0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0004};
    vecs[3] = '{32'h0000_2001, 1'b0, 32'h0, 2, 4, 32'h0000_2000, 32'h0000_2008, 32'h0000_200C};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_pc4", out_pc4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    exp_req_addr = 32'h0000_0000;

    // Streaming from reset, latency 1, decode always ready.
    lat = 1; rdy_mode = 0; out_ready = 1'b1; clear_logs();
    repeat (16) step();
    check("stream_first_pc", pop_pc.size() > 0 ? pop_pc[0] : 32'hDEAD_BEEF, 32'h0);
    check("stream_first_lat", pop_cyc.size() > 0 ? pop_cyc[0] : -1, 32'(1 + FIFO_LAT));
    begin
      int n = 0;
      foreach (pop_cyc[i]) if (pop_cyc[i] >= 4) n++;
      check("stream_throughput", n, 32'd12);
    end
    drain();

    // Decode stall: credit limits to DEPTH accepts, then release.
    lat = 2; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    step();
    redirect_valid = 1'b0; n_acc = 0; rdy_mode = 0;
    repeat (10) step();
    check("credit_accepts", n_acc, 32'd4);
    check("credit_req_low", {31'b0, imem_req_valid}, 32'd0);
    clear_logs(); out_ready = 1'b1;
    repeat (20) step();
    check("release_pops", pop_pc.size() >= 8, 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < pop_pc.size()) check("release_order", pop_pc[i], 32'h0000_0500 + 32'(4*i));
    drain();

    // Redirect scenarios.
    for (int v = 0; v < 4; v++) begin
      drain();
      lat = vecs[v].lat; out_ready = 1'b0; rdy_mode = 0; n_acc = 0;
      repeat (vecs[v].pre) step();
      check("pre_accepts", n_acc, 32'(vecs[v].pre));
      redirect_valid = 1'b1; redirect_pc = vecs[v].rpc;
      step();
      if (vecs[v].second) begin
        redirect_pc = vecs[v].rpc2;
        step();
      end
      redirect_valid = 1'b0;
      clear_logs(); out_ready = 1'b1;
      repeat (30) step();
      check("vec_pops", pop_pc.size() >= 3, 32'd1);
      if (pop_pc.size() >= 3) begin
        check("vec_first_pc", pop_pc[0], vecs[v].exp_pc0);
        check("vec_pc4_1", pop_pc4[1], vecs[v].exp_pc4_1);
        check("vec_pc4_2", pop_pc4[2], vecs[v].exp_pc4_2);
      end
      if (pop_cyc.size() > 0 && acc_cyc.size() > 0)
        check("vec_resp_to_out", pop_cyc[0] - acc_cyc[0], 32'(vecs[v].lat + FIFO_LAT));
    end

    // Random backpressure on both sides with occasional redirects.
    drain();
    lat = 3; rdy_mode = 1; rand_out = 1;
    for (int i = 0; i < 300; i++) begin
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
